// File: rtl/serial_tx_scheduler.sv
// Round-robin transmit scheduler: grants one requester at a time and serialises
// its frame as start bit, destination port, length and payload, all MSB first.
module serial_tx_scheduler #(
  parameter int N_REQ  = 4,
  parameter int PORT_W = 2,
  parameter int LEN_W  = 4,
  parameter int DATA_W = 15,
  parameter int GAP    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clkEn,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*PORT_W-1:0]   req_port,
  input  logic [N_REQ*LEN_W-1:0]    req_len,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          gnt,
  output logic                      SerOut,
  output logic                      busy,
  output logic                      Done
);

  localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SUM_W  = PTR_W + 1;
  localparam int FLD_W  = (PORT_W > LEN_W) ? PORT_W : LEN_W;
  localparam int SH_W   = (DATA_W > FLD_W) ? DATA_W : FLD_W;
  localparam int GAP_CW = $clog2(GAP) + 1;
  localparam int CNT_W  = (FLD_W > GAP_CW) ? FLD_W : GAP_CW;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_PORT, S_LEN, S_DATA, S_GAP
  } state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SH_W-1:0]     sh_q, sh_d;
  logic [PORT_W-1:0]   port_q, port_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic                found;
  logic [PTR_W-1:0]    win;
  logic [SUM_W-1:0]    sum;

  // Search upward from ptr+1 with wrap; the first asserted request wins.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    sum   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      sum = {1'b0, ptr_q} + SUM_W'(k);
      if (sum >= SUM_W'(N_REQ)) sum = sum - SUM_W'(N_REQ);
      if (!found && req[sum[PTR_W-1:0]]) begin
        found = 1'b1;
        win   = sum[PTR_W-1:0];
      end
    end
  end

  // NOTE: every variable gets its hold value before any branch, so no path
  // through this block can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    port_d  = port_q;
    len_d   = len_q;
    data_d  = data_q;
    if (clkEn) begin
      gnt_d = '0;
      cnt_d = cnt_q - 1'b1;
      sh_d  = sh_q << 1;
      unique case (state_q)
        S_IDLE: begin
          if (found) begin
            state_d = S_START;
            ptr_d   = win;
            gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << win;
            port_d  = req_port[int'(win)*PORT_W +: PORT_W];
            len_d   = req_len[int'(win)*LEN_W +: LEN_W];
            data_d  = req_data[int'(win)*DATA_W +: DATA_W];
          end
        end
        S_START: begin
          state_d = S_PORT;
          cnt_d   = CNT_W'(PORT_W - 1);
          sh_d    = SH_W'(port_q) << (SH_W - PORT_W);
        end
        S_PORT: begin
          if (cnt_q == '0) begin
            state_d = S_LEN;
            cnt_d   = CNT_W'(LEN_W - 1);
            sh_d    = SH_W'(len_q) << (SH_W - LEN_W);
          end
        end
        S_LEN: begin
          if (cnt_q == '0) begin
            if (len_q != '0) begin
              state_d = S_DATA;
              cnt_d   = CNT_W'(len_q - 1'b1);
              // Left-align data[L-1:0]; bits above L fall off the top.
              sh_d    = SH_W'(data_q) << (SH_W - int'(len_q));
            end else begin
              state_d = S_GAP;
              cnt_d   = CNT_W'(GAP - 1);
            end
          end
        end
        S_DATA: begin
          if (cnt_q == '0) begin
            state_d = S_GAP;
            cnt_d   = CNT_W'(GAP - 1);
          end
        end
        S_GAP: begin
          if (cnt_q == '0) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= PTR_W'(N_REQ - 1);
      gnt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: the latched fields and shifter are left unreset; they are always
  // loaded before the state machine reads them.
  always_ff @(posedge clk) begin
    sh_q   <= sh_d;
    port_q <= port_d;
    len_q  <= len_d;
    data_q <= data_d;
  end

  always_comb begin
    SerOut = 1'b1;
    unique case (state_q)
      S_START:              SerOut = 1'b0;
      S_PORT, S_LEN, S_DATA: SerOut = sh_q[SH_W-1];
      default:              SerOut = 1'b1;
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign Done = (state_q == S_GAP) && (cnt_q == CNT_W'(GAP - 1));
  assign gnt  = gnt_q;

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Bench for serial_tx_scheduler: directed scenarios plus random traffic, each
// cycle compared against a frame-queue reference model.
module tb_serial_tx_scheduler;

  localparam int N_REQ  = 4;
  localparam int PORT_W = 2;
  localparam int LEN_W  = 4;
  localparam int DATA_W = 15;
  localparam int GAP    = 1;
  localparam int OUT_W  = N_REQ + 3;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    clkEn;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*PORT_W-1:0] req_port;
  logic [N_REQ*LEN_W-1:0]  req_len;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        gnt;
  logic                    SerOut;
  logic                    busy;
  logic                    Done;
  logic [OUT_W-1:0]        obs;

  always #5 clk = ~clk;

  serial_tx_scheduler #(
    .N_REQ(N_REQ), .PORT_W(PORT_W), .LEN_W(LEN_W), .DATA_W(DATA_W), .GAP(GAP)
  ) dut (
    .clk(clk), .rst(rst), .clkEn(clkEn), .req(req), .req_port(req_port),
    .req_len(req_len), .req_data(req_data), .gnt(gnt), .SerOut(SerOut),
    .busy(busy), .Done(Done)
  );

  assign obs = {gnt, SerOut, busy, Done};

  int checks = 0;
  int errors = 0;

  // Reference model: whole frame as a list of line bits, walked one per enabled period.
  bit               m_active = 1'b0;
  int               m_pos    = 0;
  int               m_flen   = 0;
  int               m_ptr    = N_REQ - 1;
  logic [N_REQ-1:0] m_gnt    = '0;
  bit               m_bits[$];

  task automatic build_frame(input int w);
    logic [PORT_W-1:0] p;
    logic [LEN_W-1:0]  l;
    logic [DATA_W-1:0] d;
    p = req_port[w*PORT_W +: PORT_W];
    l = req_len[w*LEN_W +: LEN_W];
    d = req_data[w*DATA_W +: DATA_W];
    m_bits.delete();
    m_bits.push_back(1'b0);
    for (int b = PORT_W - 1; b >= 0; b--) m_bits.push_back(p[b]);
    for (int b = LEN_W - 1; b >= 0; b--) m_bits.push_back(l[b]);
    for (int b = int'(l) - 1; b >= 0; b--) m_bits.push_back(d[b]);
    m_flen = m_bits.size();
    repeat (GAP) m_bits.push_back(1'b1);
  endtask

  task automatic model_edge();
    int w;
    int idx;
    if (rst) begin
      m_active = 1'b0;
      m_gnt    = '0;
      m_ptr    = N_REQ - 1;
    end else if (clkEn) begin
      m_gnt = '0;
      if (m_active) begin
        m_pos++;
        if (m_pos >= m_bits.size()) m_active = 1'b0;
      end else if (req != '0) begin
        w = -1;
        for (int k = 1; k <= N_REQ; k++) begin
          idx = (m_ptr + k) % N_REQ;
          if (w < 0 && req[idx]) w = idx;
        end
        build_frame(w);
        m_ptr    = w;
        m_gnt[w] = 1'b1;
        m_active = 1'b1;
        m_pos    = 0;
      end
    end
  endtask

  function automatic logic [OUT_W-1:0] model_out();
    logic ser;
    ser = m_active ? m_bits[m_pos] : 1'b1;
    return {m_gnt, ser, m_active, m_active && (m_pos == m_flen)};
  endfunction

  // Model consumes the inputs the DUT sees at this edge; outputs sampled 1 after.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input int i, input logic [PORT_W-1:0] p,
                            input logic [LEN_W-1:0] l, input logic [DATA_W-1:0] d);
    req_port[i*PORT_W +: PORT_W] = p;
    req_len[i*LEN_W +: LEN_W]    = l;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic randomize_fields();
    for (int i = 0; i < N_REQ; i++)
      set_fields(i, PORT_W'($urandom), LEN_W'($urandom), DATA_W'($urandom));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    step();
    rst   = 1'b0;
    clkEn = 1'b1;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    clkEn = 1'b0;
    req   = '1;
    step();
    step();
    checks++;
    if (obs !== model_out()) begin
      errors++; $display("FAIL reset_model got %b want %b", obs, model_out());
    end
    checks++;
    if (obs !== {{N_REQ{1'b0}}, 3'b100}) begin
      errors++; $display("FAIL reset_values got %b want %b", obs, {{N_REQ{1'b0}}, 3'b100});
    end
    rst   = 1'b0;
    clkEn = 1'b1;
    req   = '0;
    step();
    checks++;
    if (obs !== model_out()) begin
      errors++; $display("FAIL reset_idle got %b want %b", obs, model_out());
    end
  endtask

  task automatic test_single();
    logic [10:0]       want_ser = 11'b0_10_0011_101_1;
    logic [10:0]       got_ser  = '0;
    logic [DATA_W-1:0] d;
    int busy_cnt = 0, done_cnt = 0, done_at = -1, gnt_cnt = 0;
    do_reset();
    randomize_fields();
    d      = DATA_W'($urandom);
    d[2:0] = 3'b101;
    set_fields(0, 2'b10, 4'd3, d);
    req = 4'b0001;
    for (int c = 0; c < 14; c++) begin
      step();
      if (c == 0) req = '0;
      checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL single_model cyc %0d got %b want %b", c, obs, model_out());
      end
      if (c < 11) got_ser[10-c] = SerOut;
      busy_cnt += int'(busy);
      if (Done) begin done_cnt++; done_at = c; end
      if (gnt == 4'b0001) gnt_cnt++;
    end
    checks++;
    if (got_ser !== want_ser) begin
      errors++; $display("FAIL single_bits got %b want %b", got_ser, want_ser);
    end
    checks++;
    if (busy_cnt != 11 || gnt_cnt != 1) begin
      errors++; $display("FAIL single_busy_gnt got busy %0d gnt %0d want 11 1", busy_cnt, gnt_cnt);
    end
    checks++;
    if (done_cnt != 1 || done_at != 10) begin
      errors++; $display("FAIL single_done got cnt %0d at %0d want 1 at 10", done_cnt, done_at);
    end
  endtask

  task automatic test_round_robin();
    logic [N_REQ-1:0] seen[$];
    logic [N_REQ-1:0] want;
    do_reset();
    for (int i = 0; i < N_REQ; i++)
      set_fields(i, PORT_W'($urandom), 4'd1, DATA_W'($urandom));
    req = '1;
    for (int c = 0; c < 200 && seen.size() < 5; c++) begin
      step();
      checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL rr_model cyc %0d got %b want %b", c, obs, model_out());
      end
      if (gnt != '0) seen.push_back(gnt);
    end
    req = '0;
    for (int c = 0; c < 40 && busy; c++) begin
      step();
      checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL rr_drain cyc %0d got %b want %b", c, obs, model_out());
      end
    end
    checks++;
    if (seen.size() != 5) begin
      errors++; $display("FAIL rr_count got %0d want 5", seen.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        want = '0;
        want[i % N_REQ] = 1'b1;
        checks++;
        if (seen[i] !== want) begin
          errors++; $display("FAIL rr_order idx %0d got %b want %b", i, seen[i], want);
        end
      end
    end
  endtask

  task automatic test_zero_len();
    logic [7:0] want_ser = 8'b0_11_0000_1;
    logic [7:0] got_ser  = '0;
    int done_at = -1, busy_cnt = 0;
    do_reset();
    randomize_fields();
    set_fields(2, 2'b11, 4'd0, DATA_W'($urandom));
    req = 4'b0100;
    for (int c = 0; c < 11; c++) begin
      step();
      if (c == 0) req = '0;
      checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL zero_model cyc %0d got %b want %b", c, obs, model_out());
      end
      if (c < 8) got_ser[7-c] = SerOut;
      busy_cnt += int'(busy);
      if (Done) done_at = c;
    end
    checks++;
    if (got_ser !== want_ser || busy_cnt != 8 || done_at != 7) begin
      errors++;
      $display("FAIL zero_len got bits %b busy %0d done@%0d want %b 8 7",
               got_ser, busy_cnt, done_at, want_ser);
    end
  endtask

  task automatic test_reset_mid();
    logic [N_REQ-1:0] got = '0;
    logic [LEN_W-1:0] l;
    int busy_cnt;
    do_reset();
    randomize_fields();
    set_fields(0, PORT_W'($urandom), 4'd7, DATA_W'($urandom));
    req = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      step();
      req = '0;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (obs !== {{N_REQ{1'b0}}, 3'b100} || obs !== model_out()) begin
      errors++; $display("FAIL rst_mid got %b want %b", obs, {{N_REQ{1'b0}}, 3'b100});
    end
    l = LEN_W'($urandom_range(1, 15));
    set_fields(1, PORT_W'($urandom), l, DATA_W'($urandom));
    req = 4'b0010;
    for (int c = 0; c < 10 && got == '0; c++) begin
      step();
      checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL rst_regrant cyc %0d got %b want %b", c, obs, model_out());
      end
      got = gnt;
    end
    req = '0;
    checks++;
    if (got !== 4'b0010) begin
      errors++; $display("FAIL rst_gnt got %b want 0010", got);
    end
    busy_cnt = int'(busy);
    for (int c = 0; c < 80 && busy; c++) begin
      step();
      checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL rst_frame cyc %0d got %b want %b", c, obs, model_out());
      end
      busy_cnt += int'(busy);
    end
    checks++;
    if (busy_cnt != 1 + PORT_W + LEN_W + int'(l) + GAP) begin
      errors++;
      $display("FAIL rst_frame_len got %0d want %0d", busy_cnt, 1 + PORT_W + LEN_W + int'(l) + GAP);
    end
  endtask

  task automatic test_throttle();
    logic [10:0]       want_ser = 11'b0_10_0011_101_1;
    logic [DATA_W-1:0] d;
    int bad_bits = 0, gnt_cnt = 0;
    do_reset();
    randomize_fields();
    d      = DATA_W'($urandom);
    d[2:0] = 3'b101;
    set_fields(0, 2'b10, 4'd3, d);
    for (int c = 0; c < 52; c++) begin
      clkEn = (c % 4 == 0);
      req   = (c == 0) ? 4'b0001 : 4'b0000;
      step();
      checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL throttle_model cyc %0d got %b want %b", c, obs, model_out());
      end
      if (c < 44 && SerOut !== want_ser[10 - c/4]) bad_bits++;
      if (gnt == 4'b0001) gnt_cnt++;
    end
    clkEn = 1'b1;
    checks++;
    if (bad_bits != 0 || gnt_cnt != 4) begin
      errors++; $display("FAIL throttle got bad_bits %0d gnt_cycles %0d want 0 4", bad_bits, gnt_cnt);
    end
  endtask

  task automatic test_late_wrap();
    logic [N_REQ-1:0] seen[3];
    int at[3];
    int n = 0;
    do_reset();
    randomize_fields();
    set_fields(3, PORT_W'($urandom), 4'd4, DATA_W'($urandom));
    req = 4'b1000;
    for (int c = 0; c < 300 && n < 3; c++) begin
      if (c == 7) req = 4'b1001;
      step();
      checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL late_model cyc %0d got %b want %b", c, obs, model_out());
      end
      if (gnt != '0) begin
        seen[n] = gnt;
        at[n]   = c;
        n++;
        if (n == 3) req = '0;
      end
    end
    for (int c = 0; c < 60 && busy; c++) step();
    checks++;
    if (n != 3) begin
      errors++; $display("FAIL late_count got %0d want 3", n);
    end else begin
      checks++;
      if (seen[0] !== 4'b1000 || seen[1] !== 4'b0001 || seen[2] !== 4'b1000) begin
        errors++; $display("FAIL late_order got %b %b %b want 1000 0001 1000", seen[0], seen[1], seen[2]);
      end
      checks++;
      if (at[1] != 1 + PORT_W + LEN_W + 4 + GAP + 1) begin
        errors++; $display("FAIL late_spacing got %0d want %0d", at[1], 1 + PORT_W + LEN_W + 4 + GAP + 1);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 7) == 0) req = N_REQ'($urandom);
      if ($urandom_range(0, 3) == 0) randomize_fields();
      clkEn = ($urandom_range(0, 3) != 0);
      rst   = ($urandom_range(0, 299) == 0);
      step();
      checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL random cyc %0d got %b want %b", c, obs, model_out());
      end
    end
    rst   = 1'b0;
    clkEn = 1'b1;
    req   = '0;
  endtask

  initial begin
    rst      = 1'b1;
    clkEn    = 1'b1;
    req      = '0;
    req_port = '0;
    req_len  = '0;
    req_data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_zero_len();
    test_reset_mid();
    test_throttle();
    test_late_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
